// File: rtl/multicycle_control_unit_pkg.sv
// mcu_pkg: constants and types shared by the multicycle control unit.
//   - opcode / funct encodings of the supported instruction subset
//   - ALU operation codes and next-PC select codes
//   - FSM state enum, latched instruction class, packed control-word struct
// Optional feature macro: MCU_JAL_EN (adds JAL, opcode 3).
package mcu_pkg;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_J     = 2;
    localparam int unsigned OP_JAL   = 3;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_BNE   = 5;
    localparam int unsigned OP_ADDI  = 8;
    localparam int unsigned OP_LW    = 35;
    localparam int unsigned OP_SW    = 43;

    localparam int unsigned FN_JR  = 8;
    localparam int unsigned FN_ADD = 32;
    localparam int unsigned FN_SUB = 34;

    localparam int unsigned ALU_NOP = 0;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 6;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_JR,
        CLS_J,
        CLS_JAL,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_ILL
    } inst_cls_e;

    // Single-bit control outputs plus next-PC select, gathered so that the
    // whole word can be defaulted and reset-masked in one assignment.
    typedef struct packed {
        logic    imem_req;
        logic    dmem_req;
        logic    dmem_we;
        logic    ir_write;
        logic    pc_write;
        logic    reg_write;
        logic    link_write;
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    illegal;
        pc_src_e pc_src;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// mcu_if: datapath/memory <-> control unit signal bundle.
//   master modport: control unit (reads IR fields / flags / ready strobes,
//                   drives requests, enables, selects, debug state)
//   slave modport : datapath + memory side
// Inputs to control : opcode, funct, zero, imem_ready, dmem_ready
// Outputs of control: imem_req, dmem_req, dmem_we, ir_write, pc_write,
//                     reg_write, link_write, reg_dst, alu_src, mem_to_reg,
//                     pc_src[1:0], alu_op, illegal, state_o[2:0]
interface mcu_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALU_OP_W = 3
) ();
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                dmem_req;
    logic                dmem_we;
    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic                link_write;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic [1:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
    logic [2:0]          state_o;

    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
               link_write, reg_dst, alu_src, mem_to_reg, pc_src, alu_op,
               illegal, state_o
    );

    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
               link_write, reg_dst, alu_src, mem_to_reg, pc_src, alu_op,
               illegal, state_o
    );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// mcu_decode: combinational instruction classifier.
//   opcode_i / funct_i -> cls_o (instruction class), alu_op_o (EXEC ALU op)
// Optional feature macro: MCU_JAL_EN (opcode 3 classified as JAL, else illegal).
module mcu_decode
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output inst_cls_e           cls_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);

    always_comb begin
        cls_o    = CLS_ILL;
        alu_op_o = ALU_OP_W'(ALU_NOP);
        if (opcode_i == OPCODE_W'(OP_RTYPE)) begin
            if (funct_i == FUNCT_W'(FN_JR)) begin
                cls_o = CLS_JR;
            end else begin
                cls_o = CLS_R;
                if (funct_i == FUNCT_W'(FN_ADD)) begin
                    alu_op_o = ALU_OP_W'(ALU_ADD);
                end else if (funct_i == FUNCT_W'(FN_SUB)) begin
                    alu_op_o = ALU_OP_W'(ALU_SUB);
                end
            end
        end else if (opcode_i == OPCODE_W'(OP_J)) begin
            cls_o = CLS_J;
`ifdef MCU_JAL_EN
        end else if (opcode_i == OPCODE_W'(OP_JAL)) begin
            cls_o = CLS_JAL;
`endif
        end else if (opcode_i == OPCODE_W'(OP_ADDI)) begin
            cls_o    = CLS_ADDI;
            alu_op_o = ALU_OP_W'(ALU_ADD);
        end else if (opcode_i == OPCODE_W'(OP_LW)) begin
            cls_o    = CLS_LW;
            alu_op_o = ALU_OP_W'(ALU_ADD);
        end else if (opcode_i == OPCODE_W'(OP_SW)) begin
            cls_o    = CLS_SW;
            alu_op_o = ALU_OP_W'(ALU_ADD);
        end else if (opcode_i == OPCODE_W'(OP_BEQ)) begin
            cls_o    = CLS_BEQ;
            alu_op_o = ALU_OP_W'(ALU_SUB);
        end else if (opcode_i == OPCODE_W'(OP_BNE)) begin
            cls_o    = CLS_BNE;
            alu_op_o = ALU_OP_W'(ALU_SUB);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB/TRAP controller for a
// multicycle datapath.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset; all outputs forced 0 while low
//   bus   - mcu_if.master: IR fields, zero flag, memory ready strobes in;
//           memory requests, datapath enables/selects, alu_op, illegal,
//           state_o out
// Optional feature macro: MCU_JAL_EN (JAL: jump + link write from DECODE).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    mcu_if.master  bus
);

    state_e              state_q, state_d;
    inst_cls_e           cls_q, cls_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;

    inst_cls_e           dec_cls;
    logic [ALU_OP_W-1:0] dec_alu_op;

    ctrl_t               ctrl, ctrl_o;
    logic [ALU_OP_W-1:0] alu_op;

    mcu_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cls_q    <= CLS_NONE;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            alu_op_q <= alu_op_d;
        end
    end

    always_comb begin
        ctrl     = '0;
        alu_op   = '0;
        state_d  = state_q;
        cls_d    = cls_q;
        alu_op_d = alu_op_q;

        case (state_q)
            S_FETCH: begin
                ctrl.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_PLUS4;
                    state_d       = S_DECODE;
                end
            end

            S_DECODE: begin
                cls_d    = dec_cls;
                alu_op_d = dec_alu_op;
                case (dec_cls)
                    CLS_J: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_JUMP;
                        state_d       = S_FETCH;
                    end
                    CLS_JR: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_REG;
                        state_d       = S_FETCH;
                    end
`ifdef MCU_JAL_EN
                    CLS_JAL: begin
                        ctrl.pc_write   = 1'b1;
                        ctrl.pc_src     = PC_JUMP;
                        ctrl.link_write = 1'b1;
                        ctrl.reg_write  = 1'b1;
                        state_d         = S_FETCH;
                    end
`else
                    CLS_JAL:  state_d = S_TRAP;
`endif
                    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE:
                        state_d = S_EXEC;
                    default:  state_d = S_TRAP;
                endcase
            end

            S_EXEC: begin
                alu_op = alu_op_q;
                case (cls_q)
                    CLS_R: begin
                        ctrl.reg_dst = 1'b1;
                        state_d      = S_WB;
                    end
                    CLS_ADDI: begin
                        ctrl.alu_src = 1'b1;
                        state_d      = S_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ctrl.alu_src = 1'b1;
                        state_d      = S_MEM;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        // Branch taken when the equality test agrees with the opcode.
                        if ((cls_q == CLS_BEQ) == bus.zero) begin
                            ctrl.pc_write = 1'b1;
                            ctrl.pc_src   = PC_BRANCH;
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.dmem_we  = (cls_q == CLS_SW);
                if (bus.dmem_ready) begin
                    state_d = (cls_q == CLS_SW) ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (cls_q == CLS_LW);
                ctrl.reg_dst    = (cls_q == CLS_R);
                state_d         = S_FETCH;
            end

            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are masked combinationally so an outstanding request drops in
    // the same cycle rst_n is sampled low, not one cycle later.
    assign ctrl_o = rst_n ? ctrl : '0;

    assign bus.imem_req   = ctrl_o.imem_req;
    assign bus.dmem_req   = ctrl_o.dmem_req;
    assign bus.dmem_we    = ctrl_o.dmem_we;
    assign bus.ir_write   = ctrl_o.ir_write;
    assign bus.pc_write   = ctrl_o.pc_write;
    assign bus.reg_write  = ctrl_o.reg_write;
    assign bus.link_write = ctrl_o.link_write;
    assign bus.reg_dst    = ctrl_o.reg_dst;
    assign bus.alu_src    = ctrl_o.alu_src;
    assign bus.mem_to_reg = ctrl_o.mem_to_reg;
    assign bus.illegal    = ctrl_o.illegal;
    assign bus.pc_src     = ctrl_o.pc_src;
    assign bus.alu_op     = rst_n ? alu_op : '0;
    assign bus.state_o    = rst_n ? state_q : '0;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 6: opcode field width.
REQ-002 Parameter FUNCT_W, default 6: funct field width.
REQ-003 Parameter ALU_OP_W, default 3: ALU operation code width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 opcode  input  OPCODE_W  instruction opcode from datapath IR; valid from DECODE onward.
REQ-007 funct  input  FUNCT_W  R-type funct from IR.
REQ-008 zero  input  1  ALU result-is-zero flag, valid in EXEC.
REQ-009 imem_ready / dmem_ready  input  1 each  memory completion strobes.
REQ-010 imem_req / dmem_req / dmem_we  output  1 each  memory request; dmem_we=1 marks write.
REQ-011 ir_write, pc_write, reg_write, link_write, reg_dst, alu_src, mem_to_reg  output  1 each  datapath enables and selects.
REQ-012 pc_src  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
REQ-013 alu_op  output  ALU_OP_W  ADD=010, SUB=110, other=000.
REQ-014 illegal  output  1  sticky illegal-instruction flag.
REQ-015 state_o  output  3  current state encoding for debug.

Function
REQ-016 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; outputs decoded from state plus latched class, all 0 when not asserted.
REQ-017 FETCH: imem_req=1 held until imem_ready; in the imem_ready cycle ir_write=1, pc_write=1, pc_src=00, next DECODE; otherwise remain FETCH.
REQ-018 DECODE: latch instruction class; J -> pc_write=1, pc_src=10, next FETCH; R-type funct 8 (JR) -> pc_write=1, pc_src=11, next FETCH; R-type other, ADDI(8), LW(35), SW(43), BEQ(4), BNE(5) -> EXEC; any other opcode -> TRAP.
REQ-019 EXEC: R-type alu_op from funct (32 ADD, 34 SUB, else 000), reg_dst=1, next WB; ADDI alu_src=1, alu_op=ADD, next WB; LW/SW alu_src=1, alu_op=ADD, next MEM.
REQ-020 EXEC branch: alu_op=SUB; pc_write=1, pc_src=01 iff (BEQ and zero) or (BNE and not zero); next FETCH.
REQ-021 MEM: dmem_req=1 held until dmem_ready; dmem_we=1 for SW; on dmem_ready SW -> FETCH, LW -> WB.
REQ-022 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LW; reg_dst=1 for R-type; next FETCH.
REQ-023 Latency with zero-wait memory (ready in first request cycle): J/JR 2, branch 3, R/ADDI/SW 4, LW 5 cycles; each wait cycle adds one.
REQ-024 TRAP: illegal=1, all other outputs 0, remain until reset.
REQ-025 imem_ready/dmem_ready SHALL be ignored outside FETCH/MEM respectively.
REQ-026 Never assert pc_write and reg_write in the same cycle except JAL (REQ-030).

Reset
REQ-027 rst_n=0 at a clock edge: state FETCH, latched class cleared, illegal=0; all outputs 0 while rst_n=0.
REQ-028 Reset mid-transaction (FETCH/MEM waiting) SHALL abort; the request drops in the cycle rst_n is sampled low; no write-enable is asserted.
REQ-029 First cycle after rst_n returns high: FETCH with imem_req=1.

Configuration
REQ-030 Macro MCU_JAL_EN defined: opcode 3 (JAL) in DECODE asserts pc_write=1, pc_src=10, link_write=1, reg_write=1, next FETCH.
REQ-031 MCU_JAL_EN undefined: opcode 3 is illegal (-> TRAP); link_write tied 0.

Structure
REQ-032 Shared package mcu_pkg SHALL hold opcode/funct constants, alu_op codes, pc_src codes, state enum.
REQ-033 Natural sub-module: mcu_decode (combinational opcode/funct -> instruction class, alu_op); FSM and registers in the top module.

Verification
REQ-034 ADD (op 0, funct 32), zero-wait memory -> states F,D,E,W; alu_op=010 in EXEC; reg_write=1 only in WB cycle 4.
REQ-035 LW (op 35), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, mem_to_reg=1 with reg_write in WB; total 8 cycles.
REQ-036 BEQ zero=1 -> pc_write=1, pc_src=01 in EXEC; BNE zero=1 -> pc_write=0 in EXEC; both return to FETCH.
REQ-037 Opcode 63 -> TRAP, illegal=1 held 10 cycles; rst_n low 1 cycle -> illegal=0, FETCH.
REQ-038 rst_n low during MEM wait of SW -> dmem_req=0 in the cycle rst_n is sampled low; no reg_write; FETCH afterwards.
REQ-039 Opcode 3 with MCU_JAL_EN -> link_write=reg_write=pc_write=1, pc_src=10 in DECODE; without MCU_JAL_EN -> TRAP.
